// File: rtl/cm0_mtx_ahb_master_pkg.sv
// Shared AHB-Lite encodings for the matrix initiator (HTRANS, HRESP, HBURST, HSIZE).
package cm0_mtx_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/cm0_mtx_ahb_master_if.sv
// Request/response port plus AHB initiator signals; 'master' is the bridge view,
// 'slave' is the view of whatever drives requests and models the bus.
interface cm0_mtx_ahb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_size;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              busy;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic              HMASTLOCK;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/cm0_mtx_ahb_master.sv
// Single-transfer AHB initiator with address (A) and data (D) pipeline stages.
// Optional CM0_MTX_AHB_MASTER_ERR_CANCEL_EN: withdraw the queued address phase on ERROR.
module cm0_mtx_ahb_master
    import cm0_mtx_ahb_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    cm0_mtx_ahb_master_if.master bus
);

    logic              a_valid_q, a_valid_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic              a_write_q, a_write_d;
    logic [2:0]        a_size_q, a_size_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
    logic              d_valid_q, d_valid_d;
    logic              d_write_q, d_write_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic              resp_err, err1, req_ready, accept;
`ifdef CM0_MTX_AHB_MASTER_ERR_CANCEL_EN
    logic              err1_q, err1_d;
    logic              cancel_pend_q, cancel_pend_d;
    logic              cancel_fire_q, cancel_fire_d;
`endif

    always_comb begin
        resp_err    = (bus.HRESP != HRESP_OKAY);
        // First cycle of a two-cycle error response looks like a wait state.
        err1        = resp_err & ~bus.HREADY;
        req_ready   = ~a_valid_q | (bus.HREADY & ~err1);
`ifdef CM0_MTX_AHB_MASTER_ERR_CANCEL_EN
        err1_d        = err1 & d_valid_q;
        cancel_pend_d = cancel_pend_q;
        cancel_fire_d = 1'b0;
        if (err1 | err1_q) req_ready = 1'b0;
`endif
        accept      = bus.req_valid & req_ready;

        a_valid_d   = a_valid_q;
        a_addr_d    = a_addr_q;
        a_write_d   = a_write_q;
        a_size_d    = a_size_q;
        a_wdata_d   = a_wdata_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_error_d = 1'b0;

        if (bus.HREADY) begin
            d_valid_d = a_valid_q;
            a_valid_d = 1'b0;
            if (a_valid_q) begin
                d_write_d = a_write_q;
                hwdata_d  = a_wdata_q;
            end
            if (d_valid_q) begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = d_write_q ? '0 : bus.HRDATA;
                rsp_error_d = resp_err;
            end
        end

        if (accept) begin
            a_valid_d = 1'b1;
            a_addr_d  = bus.req_addr;
            a_write_d = bus.req_write;
            a_size_d  = bus.req_size;
            a_wdata_d = bus.req_wdata;
        end

`ifdef CM0_MTX_AHB_MASTER_ERR_CANCEL_EN
        if (err1 & d_valid_q & a_valid_q) begin
            a_valid_d     = 1'b0;
            cancel_pend_d = 1'b1;
        end
        // The withdrawn request answers one cycle after the faulted one.
        if (cancel_pend_q & bus.HREADY & d_valid_q) begin
            cancel_pend_d = 1'b0;
            cancel_fire_d = 1'b1;
        end
        if (cancel_fire_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid_q   <= 1'b0;
            a_addr_q    <= '0;
            a_write_q   <= 1'b0;
            a_size_q    <= '0;
            a_wdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_addr_q    <= a_addr_d;
            a_write_q   <= a_write_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

`ifdef CM0_MTX_AHB_MASTER_ERR_CANCEL_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err1_q        <= 1'b0;
            cancel_pend_q <= 1'b0;
            cancel_fire_q <= 1'b0;
        end else begin
            err1_q        <= err1_d;
            cancel_pend_q <= cancel_pend_d;
            cancel_fire_q <= cancel_fire_d;
        end
    end
`endif

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.busy      = a_valid_q | d_valid_q;
    assign bus.HTRANS    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = a_addr_q;
    assign bus.HWRITE    = a_write_q;
    assign bus.HSIZE     = a_size_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_cm0_mtx_ahb_master.sv
// Directed + randomized bench for cm0_mtx_ahb_master against a transaction-level bus model.
module tb_cm0_mtx_ahb_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cm0_mtx_ahb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cm0_mtx_ahb_master #(.ADDR_W(32), .DATA_W(32), .HPROT_VAL(4'b0011)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        w;
        logic [2:0]  size;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    // Transaction-level model state
    req_t aq[$];          // accepted, address phase not yet taken by the bus
    rsp_t rq[$];          // completed transfers awaiting their response pulse
    bit   dp_valid = 0;
    req_t dp;
    int   dp_waits;
    bit   dp_err;
    int   dp_stage;
    logic [1:0] dp_resp;
    bit   rsp_due = 0;
    bit   cur_valid = 0;
    req_t cur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive_req(input bit v, input bit w, input logic [31:0] a,
                             input logic [2:0] s, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_size  = s;
        bus.req_wdata = d;
    endtask

    task automatic rand_cycle(input bit new_ok, input bit err_en);
        bit   acc;
        bit   exp_ready;
        rsp_t e;
        step();
        if (!cur_valid && new_ok && $urandom_range(0, 3) != 0) begin
            cur.addr  = $urandom;
            cur.w     = 1'($urandom_range(0, 1));
            cur.size  = 3'($urandom_range(0, 2));
            cur.wdata = $urandom;
            cur_valid = 1;
        end
        drive_req(cur_valid, cur.w, cur.addr, cur.size, cur.wdata);
        if (dp_valid) begin
            if (dp_err) begin
                bus.HRESP  = dp_resp;
                bus.HREADY = (dp_stage == 1);
            end else begin
                bus.HRESP  = 2'b00;
                bus.HREADY = (dp_waits == 0);
            end
        end else begin
            bus.HRESP  = 2'b00;
            bus.HREADY = 1'b1;
        end
        bus.HRDATA = $urandom;
        smp();

        chk("rnd_rsp_valid", bus.rsp_valid, rsp_due);
        if (rsp_due) begin
            e = rq.pop_front();
            chk("rnd_rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rnd_rsp_error", bus.rsp_error, e.err);
        end
        rsp_due = 0;
        chk("rnd_busy", bus.busy, (aq.size() != 0) || dp_valid);
        chk("rnd_nonseq", bus.HTRANS == 2'b10, aq.size() != 0);
        if (bus.HTRANS == 2'b10 && aq.size() != 0) begin
            chk("rnd_haddr", bus.HADDR, aq[0].addr);
            chk("rnd_hwrite", bus.HWRITE, aq[0].w);
            chk("rnd_hsize", bus.HSIZE, aq[0].size);
        end
        if (dp_valid && dp.w) chk("rnd_hwdata", bus.HWDATA, dp.wdata);
        exp_ready = (aq.size() == 0) || bus.HREADY;
        chk("rnd_ready", bus.req_ready, exp_ready);
        acc = bus.req_valid && bus.req_ready;

        if (bus.HREADY) begin
            if (dp_valid) begin
                e.rdata = dp.w ? 32'h0 : bus.HRDATA;
                e.err   = (bus.HRESP != 2'b00);
                rq.push_back(e);
                rsp_due = 1;
            end
            dp_valid = 0;
            if (aq.size() != 0) begin
                dp       = aq.pop_front();
                dp_valid = 1;
                dp_waits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                dp_err   = err_en && ($urandom_range(0, 7) == 0);
                dp_resp  = 2'($urandom_range(1, 3));
                dp_stage = 0;
            end
        end else begin
            if (dp_err) dp_stage = 1;
            else if (dp_waits > 0) dp_waits--;
        end
        if (acc) begin
            aq.push_back(cur);
            cur_valid = 0;
        end
    endtask

    initial begin
        bit done;
        bit err_en;
        drive_req(0, 0, 32'h0, 3'd0, 32'h0);
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b00;
        bus.HRDATA = 32'h0;

        // Reset values
        repeat (3) @(posedge clk);
        smp();
        chk("rst_htrans", bus.HTRANS, 2'b00);
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_hwrite", bus.HWRITE, 1'b0);
        chk("rst_hsize", bus.HSIZE, 3'd0);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_error", bus.rsp_error, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("const_hburst", bus.HBURST, 3'b000);
        chk("const_hprot", bus.HPROT, 4'b0011);
        chk("const_hmastlock", bus.HMASTLOCK, 1'b0);
        step();
        rst = 1'b0;

        // Single read, zero wait states
        step(); drive_req(1, 0, 32'h2000_0010, 3'd2, 32'h0); smp();
        chk("t1_ready", bus.req_ready, 1'b1);
        step(); drive_req(0, 0, 32'h0, 3'd0, 32'h0); smp();
        chk("t1_nonseq", bus.HTRANS, 2'b10);
        chk("t1_haddr", bus.HADDR, 32'h2000_0010);
        chk("t1_hwrite", bus.HWRITE, 1'b0);
        chk("t1_hsize", bus.HSIZE, 3'd2);
        step(); bus.HRDATA = 32'hDEAD_BEEF; smp();
        chk("t1_idle_dphase", bus.HTRANS, 2'b00);
        chk("t1_busy", bus.busy, 1'b1);
        chk("t1_no_early_rsp", bus.rsp_valid, 1'b0);
        step(); bus.HRDATA = 32'h0; smp();
        chk("t1_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t1_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        chk("t1_rsp_error", bus.rsp_error, 1'b0);
        step(); smp();
        chk("t1_rsp_pulse", bus.rsp_valid, 1'b0);
        chk("t1_idle_busy", bus.busy, 1'b0);

        // Write with two wait states
        step(); drive_req(1, 1, 32'h4000_0000, 3'd2, 32'h1234_5678); smp();
        chk("t2_ready", bus.req_ready, 1'b1);
        step(); drive_req(0, 0, 32'h0, 3'd0, 32'h0); smp();
        chk("t2_nonseq", bus.HTRANS, 2'b10);
        chk("t2_hwrite", bus.HWRITE, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(); bus.HREADY = (c == 2); smp();
            chk("t2_hwdata", bus.HWDATA, 32'h1234_5678);
            chk("t2_haddr", bus.HADDR, 32'h4000_0000);
            chk("t2_no_rsp", bus.rsp_valid, 1'b0);
        end
        step(); bus.HREADY = 1'b1; smp();
        chk("t2_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t2_rsp_error", bus.rsp_error, 1'b0);
        chk("t2_rsp_rdata", bus.rsp_rdata, 32'h0);

        // Four back-to-back reads
        for (int c = 0; c < 8; c++) begin
            logic [31:0] a;
            a = 32'h1000_0000 + 32'(4 * c);
            step();
            drive_req(c < 4, 0, a, 3'd2, 32'h0);
            bus.HRDATA = (c >= 2 && c <= 5) ? 32'hA000_0000 + 32'(c - 2) : 32'h0;
            smp();
            if (c < 4) chk("t3_ready", bus.req_ready, 1'b1);
            chk("t3_htrans", bus.HTRANS, (c >= 1 && c <= 4) ? 2'b10 : 2'b00);
            chk("t3_rsp_valid", bus.rsp_valid, c >= 3 && c <= 6);
            if (c >= 3 && c <= 6) chk("t3_rsp_rdata", bus.rsp_rdata, 32'hA000_0000 + 32'(c - 3));
        end

        // ERROR on a read with a queued write behind it
        step(); drive_req(1, 0, 32'hE000_0000, 3'd2, 32'h0); smp();
        chk("t4_ready0", bus.req_ready, 1'b1);
        step(); drive_req(1, 1, 32'h3000_0004, 3'd2, 32'hCAFE_F00D); smp();
        chk("t4_ready1", bus.req_ready, 1'b1);
        chk("t4_rd_nonseq", bus.HTRANS, 2'b10);
        step(); drive_req(0, 0, 32'h0, 3'd0, 32'h0);
        bus.HRESP = 2'b01; bus.HREADY = 1'b0; smp();
        chk("t4_err1_ready", bus.req_ready, 1'b0);
        chk("t4_err1_htrans", bus.HTRANS, 2'b10);
        chk("t4_err1_hwrite", bus.HWRITE, 1'b1);
        step(); bus.HRESP = 2'b01; bus.HREADY = 1'b1; smp();
`ifdef CM0_MTX_AHB_MASTER_ERR_CANCEL_EN
        chk("t4_err2_idle", bus.HTRANS, 2'b00);
        chk("t4_err2_ready", bus.req_ready, 1'b0);
`else
        chk("t4_err2_htrans", bus.HTRANS, 2'b10);
        chk("t4_err2_haddr", bus.HADDR, 32'h3000_0004);
`endif
        step(); bus.HRESP = 2'b00; bus.HREADY = 1'b1; smp();
        chk("t4_rd_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t4_rd_rsp_error", bus.rsp_error, 1'b1);
`ifdef CM0_MTX_AHB_MASTER_ERR_CANCEL_EN
        chk("t4_cancel_busy", bus.busy, 1'b0);
`else
        chk("t4_wr_hwdata", bus.HWDATA, 32'hCAFE_F00D);
`endif
        step(); smp();
        chk("t4_wr_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t4_wr_rsp_rdata", bus.rsp_rdata, 32'h0);
`ifdef CM0_MTX_AHB_MASTER_ERR_CANCEL_EN
        chk("t4_wr_rsp_error", bus.rsp_error, 1'b1);
`else
        chk("t4_wr_rsp_error", bus.rsp_error, 1'b0);
`endif
        step(); smp();
        chk("t4_quiet", bus.rsp_valid, 1'b0);

        // Reset while the address phase waits
        step(); drive_req(1, 0, 32'h5000_0000, 3'd2, 32'h0); smp();
        step(); drive_req(0, 0, 32'h0, 3'd0, 32'h0); bus.HREADY = 1'b0; rst = 1'b1; smp();
        chk("t5_pre_nonseq", bus.HTRANS, 2'b10);
        step(); rst = 1'b0; bus.HREADY = 1'b1; smp();
        chk("t5_htrans_idle", bus.HTRANS, 2'b00);
        chk("t5_busy", bus.busy, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(); smp();
            chk("t5_no_rsp", bus.rsp_valid, 1'b0);
        end

        // RETRY response on completion counts as an error
        step(); drive_req(1, 0, 32'h6000_0008, 3'd1, 32'h0); smp();
        step(); drive_req(0, 0, 32'h0, 3'd0, 32'h0); smp();
        step(); bus.HRESP = 2'b10; bus.HREADY = 1'b1; bus.HRDATA = 32'h0000_1234; smp();
        step(); bus.HRESP = 2'b00; bus.HRDATA = 32'h0; smp();
        chk("t6_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t6_rsp_error", bus.rsp_error, 1'b1);
        chk("t6_rsp_rdata", bus.rsp_rdata, 32'h0000_1234);

        // Randomized traffic against the transaction model
`ifdef CM0_MTX_AHB_MASTER_ERR_CANCEL_EN
        err_en = 0;
`else
        err_en = 1;
`endif
        for (int c = 0; c < 600; c++) rand_cycle(1, err_en);
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            rand_cycle(0, err_en);
            done = !cur_valid && aq.size() == 0 && !dp_valid && !rsp_due;
        end
        chk("rnd_drain_done", done, 1'b1);
        chk("rnd_rsp_queue_empty", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
